alu_ctrl_sequencer: RTL and testbench

- Registered, handshaked successor to the combinational ALU control decode.
- Maps {alu_op, alu_opcode} plus an M-extension flag to a widened ALU select code.
- Issues single-cycle ops with 1-cycle latency.
- Holds multiply/divide ops for a parametrised number of cycles before presenting the result code.
- Sits between the decode stage and the execute stage, with valid/ready on both sides.

---
 rtl/alu_ctrl_sequencer.sv | 167 ++++++++++++++++
 tb/tb_alu_ctrl_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_sequencer.sv
// Registered ALU control decode with valid/ready on both sides.
// Single-cycle ops appear one cycle after accept; MUL/DIV codes are held back for MUL_LAT/DIV_LAT cycles.
module alu_ctrl_sequencer #(
  parameter int CNT_W   = 5,
  parameter int M_EN    = 1,
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       alu_op,
  input  logic [3:0]       alu_opcode,
  input  logic             m_ext,
  output logic [CNT_W-1:0] alu_cnt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);
  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int TW      = $clog2(MAX_LAT) + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, HOLD = 2'd2} state_e;

  state_e           state_q, state_d;
  logic [TW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] alu_cnt_q, alu_cnt_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;

  logic [4:0]    code;
  logic [TW-1:0] lat_m1;
  logic          m_ok, accept, load;

  assign m_ok = (M_EN != 0) && m_ext;

  always_comb begin
    code = 5'd0;
    case (alu_op)
      2'b01: begin
        case (alu_opcode[2:0])
          3'b000:         code = 5'd1;
          3'b001:         code = 5'd9;
          3'b100, 3'b110: code = 5'd10;
          3'b101, 3'b111: code = 5'd8;
          default:        code = 5'd0;
        endcase
      end
      2'b10: begin
        if (m_ok) begin
          code = {2'b10, alu_opcode[2:0]};
        end else begin
          case (alu_opcode)
            4'b1000:          code = 5'd1;
            4'b0100:          code = 5'd2;
            4'b0110:          code = 5'd3;
            4'b0111:          code = 5'd4;
            4'b0001:          code = 5'd5;
            4'b0101:          code = 5'd6;
            4'b1101:          code = 5'd7;
            4'b0010, 4'b0011: code = 5'd8;
            default:          code = 5'd0;
          endcase
        end
      end
      2'b11: begin
        casez (alu_opcode)
          4'b?100: code = 5'd2;
          4'b?110: code = 5'd3;
          4'b?111: code = 5'd4;
          4'b0001: code = 5'd5;
          4'b0101: code = 5'd6;
          4'b1101: code = 5'd7;
          4'b?010: code = 5'd8;
          4'b?011: code = 5'd11;
          default: code = 5'd0;
        endcase
      end
      default: code = 5'd0;
    endcase
  end

  // Codes 16..23 carry funct3 in the low bits; bit 2 separates DIV (20..23) from MUL.
  always_comb begin
    lat_m1 = '0;
    if (code[4]) lat_m1 = code[2] ? TW'(DIV_LAT - 1) : TW'(MUL_LAT - 1);
  end

  assign in_ready = !flush && ((state_q == IDLE) || ((state_q == HOLD) && out_ready));
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    alu_cnt_d   = alu_cnt_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    load        = 1'b0;
    case (state_q)
      IDLE: load = accept;
      WAIT: begin
        // Transition on the edge where the count hits zero so out_valid is first seen at T+L.
        if (cnt_q <= TW'(1)) begin
          state_d     = HOLD;
          cnt_d       = '0;
          out_valid_d = 1'b1;
          busy_d      = 1'b0;
        end else begin
          cnt_d = cnt_q - TW'(1);
        end
      end
      HOLD: begin
        if (out_ready) begin
          if (accept) begin
            load = 1'b1;
          end else begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      alu_cnt_d = CNT_W'(code);
      if (lat_m1 == '0) begin
        state_d     = HOLD;
        out_valid_d = 1'b1;
        busy_d      = 1'b0;
      end else begin
        state_d     = WAIT;
        cnt_d       = lat_m1;
        out_valid_d = 1'b0;
        busy_d      = 1'b1;
      end
    end
    if (flush) begin
      state_d     = IDLE;
      cnt_d       = '0;
      alu_cnt_d   = '0;
      out_valid_d = 1'b0;
      busy_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      alu_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      alu_cnt_q   <= alu_cnt_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign alu_cnt   = alu_cnt_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
endmodule

// File: tb/tb_alu_ctrl_sequencer.sv
// Scoreboard bench: the driver pushes expected {code, due cycle} on accept; the monitor pops on handshake.
module tb_alu_ctrl_sequencer;
  localparam int CNT_W   = 5;
  localparam int MUL_LAT = 3;
  localparam int DIV_LAT = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic flush = 1'b0, in_valid = 1'b0, m_ext = 1'b0, out_ready = 1'b0;
  logic [1:0] alu_op = '0;
  logic [3:0] alu_opcode = '0;
  logic in_ready, out_valid, busy;
  logic [CNT_W-1:0] alu_cnt;

  logic flush1 = 1'b0, in_valid1 = 1'b0, m_ext1 = 1'b0, out_ready1 = 1'b0;
  logic [1:0] alu_op1 = '0;
  logic [3:0] alu_opcode1 = '0;
  logic in_ready1, out_valid1, busy1;
  logic [CNT_W-1:0] alu_cnt1;

  alu_ctrl_sequencer #(.CNT_W(CNT_W), .M_EN(1), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .alu_opcode(alu_opcode), .m_ext(m_ext), .alu_cnt(alu_cnt),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy));

  alu_ctrl_sequencer #(.CNT_W(CNT_W), .M_EN(0), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut_nom (
    .clk(clk), .rst_n(rst_n), .flush(flush1), .in_valid(in_valid1), .in_ready(in_ready1),
    .alu_op(alu_op1), .alu_opcode(alu_opcode1), .m_ext(m_ext1), .alu_cnt(alu_cnt1),
    .out_valid(out_valid1), .out_ready(out_ready1), .busy(busy1));

  typedef struct {int code; int due;} exp_t;
  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic int ref_code(input int op, input int opc, input int mx, input int men);
    int f3, b3;
    f3 = opc % 8;
    b3 = opc / 8;
    case (op)
      1: case (f3)
           0: return 1;
           1: return 9;
           4, 6: return 10;
           5, 7: return 8;
           default: return 0;
         endcase
      2: begin
        if (mx != 0 && men != 0) return 16 + f3;
        case (opc)
          8: return 1;
          4: return 2;
          6: return 3;
          7: return 4;
          1: return 5;
          5: return 6;
          13: return 7;
          2, 3: return 8;
          default: return 0;
        endcase
      end
      3: case (f3)
           4: return 2;
           6: return 3;
           7: return 4;
           1: return (b3 != 0) ? 0 : 5;
           5: return (b3 != 0) ? 7 : 6;
           2: return 8;
           3: return 11;
           default: return 0;
         endcase
      default: return 0;
    endcase
  endfunction

  function automatic int ref_lat(input int c);
    if (c >= 20) return DIV_LAT;
    if (c >= 16) return MUL_LAT;
    return 1;
  endfunction

  // One cycle of stimulus; the expected in_ready comes from the scoreboard's view of what is outstanding.
  task automatic drive(input bit iv, input int op, input int opc, input int mx, input bit ordy, input bit fl);
    bit   exp_rdy;
    exp_t e;
    @(negedge clk);
    in_valid   = iv;
    alu_op     = op[1:0];
    alu_opcode = opc[3:0];
    m_ext      = mx[0];
    out_ready  = ordy;
    flush      = fl;
    #1;
    if (rst_n) begin
      exp_rdy = !fl && (q.size() == 0 || (cyc >= q[0].due && ordy));
      chk("in_ready", int'(in_ready), int'(exp_rdy));
      if (iv && exp_rdy) begin
        e.code = ref_code(op, opc, mx, 1);
        e.due  = cyc + ref_lat(e.code);
        q.push_back(e);
      end
    end
  endtask

  initial begin
    bit vis, or_s, fl_s, exp_v, exp_b;
    forever begin
      @(posedge clk);
      vis  = q.size() > 0 && cyc >= q[0].due;
      or_s = out_ready;
      fl_s = flush;
      #1;
      cyc++;
      if (!rst_n) begin
        q.delete();
      end else if (fl_s) begin
        q.delete();
        chk("flush_alu_cnt", int'(alu_cnt), 0);
      end else if (vis && or_s) begin
        void'(q.pop_front());
      end
      exp_v = q.size() > 0 && cyc >= q[0].due;
      exp_b = q.size() > 0 && cyc < q[0].due;
      chk("out_valid", int'(out_valid), int'(exp_v));
      chk("busy", int'(busy), int'(exp_b));
      if (q.size() > 0) chk("alu_cnt", int'(alu_cnt), q[0].code);
    end
  end

  initial begin
    int br[6] = '{0, 1, 4, 5, 6, 7};
    int nm[3] = '{0, 4, 8};
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // R-type SUB, then drain
    drive(1, 2, 8, 0, 1, 0);
    drive(0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 1, 0);

    // DIV with a competing op waiting on in_ready
    drive(1, 2, 4, 1, 1, 0);
    repeat (7) drive(1, 3, 0, 0, 0, 0);
    repeat (3) drive(0, 0, 0, 0, 1, 0);

    // stall in HOLD, then back-to-back replacement
    drive(1, 2, 1, 0, 1, 0);
    repeat (5) drive(1, 3, 3, 0, 0, 0);
    drive(1, 3, 3, 0, 1, 0);
    drive(0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 1, 0);

    foreach (br[i]) drive(1, 1, br[i], 0, 1, 0);
    drive(0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 1, 0);

    // asynchronous reset while a MUL is in flight
    drive(1, 2, 0, 1, 1, 0);
    drive(0, 0, 0, 0, 1, 0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    q.delete();
    #1;
    chk("rst_async_valid", int'(out_valid), 0);
    chk("rst_async_busy", int'(busy), 0);
    chk("rst_async_cnt", int'(alu_cnt), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    drive(1, 2, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 1, 0);

    // M extension disabled: m_ext is ignored
    foreach (nm[i]) begin
      @(negedge clk);
      in_valid1 = 1'b1; alu_op1 = 2'b10; alu_opcode1 = nm[i][3:0]; m_ext1 = 1'b1; out_ready1 = 1'b1;
      #1;
      chk("nom_in_ready", int'(in_ready1), 1);
      @(negedge clk);
      in_valid1 = 1'b0;
      chk("nom_valid", int'(out_valid1), 1);
      chk("nom_busy", int'(busy1), 0);
      chk("nom_cnt", int'(alu_cnt1), ref_code(2, nm[i], 1, 0));
      @(negedge clk);
      chk("nom_drain", int'(out_valid1), 0);
    end

    // flush mid-WAIT
    drive(1, 2, 4, 1, 1, 0);
    repeat (3) drive(0, 0, 0, 0, 1, 0);
    drive(1, 2, 8, 0, 1, 1);
    repeat (10) drive(0, 0, 0, 0, 1, 0);

    repeat (3000)
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 3), $urandom_range(0, 15),
            $urandom_range(0, 1), $urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0);
    repeat (12) drive(0, 0, 0, 0, 1, 0);
    chk("drain_empty", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
